// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: grants one of NUM_REQ writers into a shared holding register.
// Define SHARED_REG_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module shared_reg_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_write_en,
    output logic [DATA_WIDTH-1:0]         o_write_data,
    output logic                          o_full,
    output logic [ID_W-1:0]               o_owner_id,
    input  logic                          i_consume
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state;
    logic                grant_ok;
    logic                grant;
    logic [NUM_REQ-1:0]  sel;
    logic [ID_W-1:0]     gnt_id;
    logic [ID_W-1:0]     idx;
    logic [DATA_WIDTH-1:0] wdata;

`ifndef SHARED_REG_FIXED_PRIO_EN
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W:0]       sum;
`endif

    // A consume in the same cycle frees the slot for a back-to-back write.
    assign grant_ok = (state == EMPTY) | i_consume;
    assign grant    = grant_ok & (|i_req_valid);

    always_comb begin
        sel    = '0;
        gnt_id = '0;
        idx    = '0;
`ifndef SHARED_REG_FIXED_PRIO_EN
        sum    = '0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SHARED_REG_FIXED_PRIO_EN
            idx = ID_W'(i);
`else
            sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
`endif
            if (sel == '0 && i_req_valid[idx]) begin
                sel[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel[k]) begin
                wdata = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_req_ready  = grant ? sel : '0;
    assign o_write_en   = grant;
    assign o_write_data = grant ? wdata : '0;
    assign o_full       = (state == FULL);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= EMPTY;
            o_owner_id <= '0;
`ifndef SHARED_REG_FIXED_PRIO_EN
            rr_ptr     <= '0;
`endif
        end else begin
            if (grant) begin
                state      <= FULL;
                o_owner_id <= gnt_id;
`ifndef SHARED_REG_FIXED_PRIO_EN
                rr_ptr     <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
`endif
            end else if (i_consume) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, grant, stall, fairness, drain.
// Expectations switch with SHARED_REG_FIXED_PRIO_EN.
module tb_shared_reg_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    logic           clk;
    logic           arstn;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           write_en;
    logic [DW-1:0]  write_data;
    logic           full;
    logic [IW-1:0]  owner_id;
    logic           consume;

    int tests;
    int fails;

    logic [DW-1:0] dv [NR];

    shared_reg_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk),
        .arstn(arstn),
        .i_req_valid(req_valid),
        .i_req_data(req_data),
        .o_req_ready(req_ready),
        .o_write_en(write_en),
        .o_write_data(write_data),
        .o_full(full),
        .o_owner_id(owner_id),
        .i_consume(consume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        req_valid = '0;
        consume = 1'b0;
        dv[0] = 32'hA0A0A0A0;
        dv[1] = 32'hB1B1B1B1;
        dv[2] = 32'hDEADBEEF;
        dv[3] = 32'hD3D3D3D3;
        req_data = {dv[3], dv[2], dv[1], dv[0]};
        repeat (3) step();
        arstn = 1'b1;
        step();
        tests++;
        if ({req_ready, write_en, write_data, full, owner_id} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got rdy=%b we=%b wd=%h full=%b own=%0d want all 0",
                     req_ready, write_en, write_data, full, owner_id);
        end
    endtask

    task automatic test_first_write();
        req_valid = 4'b0100;
        #1;
        tests++;
        if (req_ready !== 4'b0100 || write_en !== 1'b1 || write_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL first_grant got rdy=%b we=%b wd=%h want 0100 1 deadbeef",
                     req_ready, write_en, write_data);
        end
        step();
        req_valid = '0;
        #1;
        tests++;
        if (full !== 1'b1 || owner_id !== 2'd2) begin
            fails++;
            $display("FAIL first_full got full=%b own=%0d want 1 2", full, owner_id);
        end
    endtask

    task automatic test_wrap_skip();
        logic [NR-1:0] e0;
        logic [NR-1:0] e1;
        logic [IW-1:0] eo;
`ifdef SHARED_REG_FIXED_PRIO_EN
        e0 = 4'b0001; e1 = 4'b0001; eo = 2'd0;
`else
        e0 = 4'b0001; e1 = 4'b0010; eo = 2'd1;
`endif
        consume = 1'b1;
        req_valid = 4'b0011;
        #1;
        tests++;
        if (req_ready !== e0 || write_data !== dv[0]) begin
            fails++;
            $display("FAIL wrap_grant0 got rdy=%b wd=%h want %b %h", req_ready, write_data, e0, dv[0]);
        end
        step();
        tests++;
        if (req_ready !== e1 || full !== 1'b1) begin
            fails++;
            $display("FAIL wrap_grant1 got rdy=%b full=%b want %b 1", req_ready, full, e1);
        end
        step();
        consume = 1'b0;
        req_valid = '0;
        #1;
        tests++;
        if (full !== 1'b1 || owner_id !== eo) begin
            fails++;
            $display("FAIL wrap_owner got full=%b own=%0d want 1 %0d", full, owner_id, eo);
        end
    endtask

    task automatic test_reset_mid();
        #2;
        arstn = 1'b0;
        #1;
        tests++;
        if (full !== 1'b0 || owner_id !== 2'd0) begin
            fails++;
            $display("FAIL async_reset got full=%b own=%0d want 0 0", full, owner_id);
        end
        #1;
        arstn = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        int exp_g [6];
        logic [NR-1:0] er;
`ifdef SHARED_REG_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0, 1};
`endif
        req_valid = 4'b1111;
        consume = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            er = 4'b0001 << exp_g[c];
            tests++;
            if (req_ready !== er || write_en !== 1'b1 || write_data !== dv[exp_g[c]]) begin
                fails++;
                $display("FAIL rr_cycle%0d got rdy=%b we=%b wd=%h want %b 1 %h",
                         c, req_ready, write_en, write_data, er, dv[exp_g[c]]);
            end
            if (c > 0) begin
                tests++;
                if (full !== 1'b1 || owner_id !== IW'(exp_g[c-1])) begin
                    fails++;
                    $display("FAIL rr_owner%0d got full=%b own=%0d want 1 %0d",
                             c, full, owner_id, exp_g[c-1]);
                end
            end
            step();
        end
        req_valid = '0;
        consume = 1'b0;
    endtask

    task automatic test_stall();
        req_valid = 4'b0001;
        consume = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0000 || write_en !== 1'b0 || write_data !== '0 || full !== 1'b1) begin
                fails++;
                $display("FAIL stall%0d got rdy=%b we=%b wd=%h full=%b want 0 0 0 1",
                         c, req_ready, write_en, write_data, full);
            end
            step();
        end
        consume = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0001 || write_en !== 1'b1 || write_data !== dv[0]) begin
            fails++;
            $display("FAIL stall_release got rdy=%b we=%b wd=%h want 0001 1 %h",
                     req_ready, write_en, write_data, dv[0]);
        end
        step();
        req_valid = '0;
        consume = 1'b0;
        #1;
        tests++;
        if (full !== 1'b1 || owner_id !== 2'd0) begin
            fails++;
            $display("FAIL stall_after got full=%b own=%0d want 1 0", full, owner_id);
        end
    endtask

    task automatic test_drain();
        consume = 1'b1;
        #1;
        tests++;
        if (write_en !== 1'b0 || req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL drain_no_write got we=%b rdy=%b want 0 0000", write_en, req_ready);
        end
        step();
        tests++;
        if (full !== 1'b0 || owner_id !== 2'd0) begin
            fails++;
            $display("FAIL drain_empty got full=%b own=%0d want 0 0", full, owner_id);
        end
        step();
        consume = 1'b0;
        #1;
        tests++;
        if (full !== 1'b0 || write_en !== 1'b0) begin
            fails++;
            $display("FAIL consume_empty got full=%b we=%b want 0 0", full, write_en);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_first_write();
        test_wrap_skip();
        test_reset_mid();
        test_round_robin();
        test_stall();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Controller that shares one nonarchitectural write-enabled holding register between NUM_REQ requesters. It grants at most one writer per cycle and drives the register's write enable and write data. It tracks register occupancy as a single-entry buffer: once written, the register stays full until the downstream consumer acknowledges it. It sits between the multicycle datapath's producer units (e.g. ALU, LSU, CSR) and the register feeding the shared result path.

## Interface
- DATA_WIDTH, 32, width of each requester's data and of the shared register
- NUM_REQ, 4, number of requesters (2..8); ID_W = $clog2(NUM_REQ)

- clk  input  1  common clock, rising edge
- arstn  input  1  asynchronous, active-low reset
- i_req_valid  input  NUM_REQ  per-requester write request; bit k belongs to requester k
- i_req_data  input  NUM_REQ*DATA_WIDTH  flattened data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_req_ready  output  NUM_REQ  one-hot grant; requester k's transfer completes on a cycle where valid[k] and ready[k] are both 1
- o_write_en  output  1  write enable to the shared register
- o_write_data  output  DATA_WIDTH  data of the granted requester; all zeros when no grant
- o_full  output  1  shared register holds unconsumed data
- o_owner_id  output  ID_W  index of the requester whose data is in the register
- i_consume  input  1  consumer acknowledges the register contents; ignored when o_full=0

## Operation
- Two states:
  - EMPTY (reset state).
  - FULL.
- Grant eligibility: grant_ok = (state==EMPTY) | (state==FULL & i_consume).
- When grant_ok and any i_req_valid is 1, exactly one requester g is selected, and in the same cycle:
  - o_req_ready[g]=1.
  - o_write_en=1.
  - o_write_data = data[g].
- Otherwise:
  - o_req_ready=0, o_write_en=0, o_write_data=0.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on i_consume with no grant.
  - FULL→FULL on i_consume with a grant (back-to-back handoff).
  - FULL with no i_consume holds; all requests stall.
- o_owner_id is loaded with g on every grant. It holds its value otherwise, including after a transition to EMPTY.
- Round-robin selection:
  - A pointer rr_ptr (ID_W bits, reset 0) marks the highest-priority index.
  - The search runs rr_ptr, rr_ptr+1, … and wraps modulo NUM_REQ.
  - After a grant to g, rr_ptr ← (g+1) mod NUM_REQ. When g=NUM_REQ-1, this wraps to 0.
  - rr_ptr does not change in cycles without a grant.
- Requesters keep valid and data stable until ready. i_req_valid must not depend combinationally on o_req_ready.
- Reset mid-operation: state returns to EMPTY, rr_ptr=0, o_owner_id=0. Any unconsumed data is discarded. The shared register is reset by the same reset network.

## Timing
- Reset values:
  - o_req_ready=0, o_write_en=0, o_write_data=0.
  - o_full=0, o_owner_id=0.
- Grant path (valid→ready, write_en, write_data) is combinational, with zero-cycle latency.
- The register captures on the clock edge that ends the grant cycle. Data is visible on the register output, and o_full=1, from the next cycle.
- i_consume→o_full fall takes one cycle. A consume with a simultaneous grant keeps o_full=1 with no bubble.
- Throughput is one write per cycle when the consumer asserts i_consume every cycle.
- o_full and o_owner_id are registered outputs.

## Configuration
- SHARED_REG_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest asserted index always wins. rr_ptr is not implemented, and o_owner_id behaviour is unchanged.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset, then idle: after arstn rises, with no valid:
  - All outputs are 0.
  - Assert valid[2] with data 0xDEADBEEF → ready[2]=1, write_en=1, write_data=0xDEADBEEF in the same cycle.
  - Next cycle: o_full=1, owner_id=2.
- Stall: while FULL with i_consume=0, hold valid[0] for 5 cycles → ready stays 0 and write_en stays 0 for all 5. Assert i_consume → ready[0]=1 that cycle and o_full stays 1.
- Round-robin fairness: hold valid=4'b1111 with i_consume=1 every cycle → grants 0,1,2,3,0,1 on consecutive cycles. With SHARED_REG_FIXED_PRIO_EN defined → grant 0 every cycle.
- Wrap and skip: rr_ptr=3 (last grant to 2), then valid=4'b0011 → grant 0, then grant 1 on the next cycle.
- Drain: FULL, i_consume=1, no valid → write_en=0 and o_full=0 next cycle. i_consume while EMPTY → no state change.
- Reset mid-operation: FULL with owner 1 and rr_ptr=2, pulse arstn low asynchronously between clock edges → o_full=0, owner_id=0 immediately. The next grant with valid=4'b1111 goes to 0.
